// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C memory target and its bus frontend.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    DEV_ADDR,
    DEV_ACK,
    PTR,
    PTR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK
  } i2c_slv_state_t;

  localparam logic ACK       = 1'b0;
  localparam logic NACK      = 1'b1;
  localparam int   BYTE_BITS = 8;

  typedef struct packed {
    logic scl_rise;
    logic scl_fall;
    logic start;
    logic stop;
  } bus_event_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes SCL/SDA into clk and flags SCL edges plus START/STOP conditions.
module i2c_bus_sync
  import i2c_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output bus_event_t ev,
  output logic       sda
);

  logic scl_meta, scl_sync, scl_prev;
  logic sda_meta, sda_sync, sda_prev;

  // Reset to the idle-bus level so leaving reset never fakes an edge or START.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_meta <= 1'b1;
      scl_sync <= 1'b1;
      scl_prev <= 1'b1;
      sda_meta <= 1'b1;
      sda_sync <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_meta <= scl_i;
      scl_sync <= scl_meta;
      scl_prev <= scl_sync;
      sda_meta <= sda_i;
      sda_sync <= sda_meta;
      sda_prev <= sda_sync;
    end
  end

  always_comb begin
    ev.scl_rise = scl_sync & ~scl_prev;
    ev.scl_fall = ~scl_sync & scl_prev;
    ev.start    = scl_sync & scl_prev & sda_prev & ~sda_sync;
    ev.stop     = scl_sync & scl_prev & ~sda_prev & sda_sync;
  end

  assign sda = sda_sync;

endmodule

// File: rtl/i2c_mem_slave.sv
// I2C memory target: address match, register pointer, auto-incrementing writes and reads.
module i2c_mem_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h1F,
  parameter int         MEM_DEPTH  = 16,
  localparam int        AW         = $clog2(MEM_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          scl_i,
  input  logic          sda_i,
  output logic          sda_oe,
  output logic          busy,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data
);

  i2c_slv_state_t       state;
  bus_event_t           ev;
  logic                 sda;
  logic [2:0]           bit_cnt;
  logic [BYTE_BITS-1:0] shift;
  logic [BYTE_BITS-1:0] rx_byte;
  logic [AW-1:0]        ptr;
  logic                 rw;
  logic                 ack_phase;
  logic [7:0]           mem [MEM_DEPTH];

  i2c_bus_sync u_sync (
    .clk   (clk),
    .rst   (rst),
    .scl_i (scl_i),
    .sda_i (sda_i),
    .ev    (ev),
    .sda   (sda)
  );

  assign rx_byte = {shift[BYTE_BITS-2:0], sda};

  // START/STOP override everything; otherwise SCL rises shift/sample and falls drive SDA.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      ptr       <= '0;
      rw        <= 1'b0;
      ack_phase <= 1'b0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else begin
      wr_en <= 1'b0;
      if (ev.start) begin
        state     <= DEV_ADDR;
        bit_cnt   <= '0;
        ack_phase <= 1'b0;
        sda_oe    <= 1'b0;
      end else if (ev.stop) begin
        state     <= IDLE;
        bit_cnt   <= '0;
        ack_phase <= 1'b0;
        sda_oe    <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          DEV_ADDR, PTR, WR_DATA: begin
            if (ev.scl_rise) begin
              shift   <= rx_byte;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (state == DEV_ADDR) begin
                  if (rx_byte[7:1] == SLAVE_ADDR) begin
                    state <= DEV_ACK;
                    rw    <= rx_byte[0];
                    busy  <= 1'b1;
                  end else begin
                    state <= IDLE;
                    busy  <= 1'b0;
                  end
                end else if (state == PTR) begin
                  ptr   <= rx_byte[AW-1:0];
                  state <= PTR_ACK;
                end else begin
                  mem[ptr] <= rx_byte;
                  wr_en    <= 1'b1;
                  wr_addr  <= ptr;
                  wr_data  <= rx_byte;
                  ptr      <= ptr + AW'(1);
                  state    <= WR_ACK;
                end
              end
            end
          end

          // First fall pulls SDA for the ACK bit, second fall ends the slot.
          DEV_ACK, PTR_ACK, WR_ACK: begin
            if (ev.scl_fall) begin
              if (!ack_phase) begin
                ack_phase <= 1'b1;
                sda_oe    <= 1'b1;
              end else begin
                ack_phase <= 1'b0;
                if (state == DEV_ACK && rw) begin
                  state  <= RD_DATA;
                  shift  <= {mem[ptr][BYTE_BITS-2:0], 1'b0};
                  sda_oe <= ~mem[ptr][BYTE_BITS-1];
                  ptr    <= ptr + AW'(1);
                end else begin
                  state  <= (state == DEV_ACK) ? PTR : WR_DATA;
                  sda_oe <= 1'b0;
                end
              end
            end
          end

          RD_DATA: begin
            if (ev.scl_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) state <= RD_ACK;
            end else if (ev.scl_fall) begin
              sda_oe <= ~shift[BYTE_BITS-1];
              shift  <= {shift[BYTE_BITS-2:0], 1'b0};
            end
          end

          // Release SDA for the master's ACK bit, then continue or finish the read.
          RD_ACK: begin
            if (ev.scl_fall) begin
              sda_oe <= 1'b0;
            end else if (ev.scl_rise) begin
              if (sda == ACK) begin
                state <= RD_DATA;
                shift <= mem[ptr];
                ptr   <= ptr + AW'(1);
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end
          end

          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_mem_slave.sv
// Randomized self-checking bench for i2c_mem_slave against a byte-level memory model.
module tb_i2c_mem_slave;

  typedef logic [7:0] byte_q_t [$];

  logic       clk;
  logic       rst;
  logic       scl;
  logic       sda_m;
  logic       sda_bus;
  logic       sda_oe;
  logic       busy;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0]  ref_mem [16];
  int          ref_ptr;
  logic [11:0] exp_wr [$];
  logic [11:0] act_wr [$];
  bit          any_oe;
  bit          any_busy;
  int          oe_hi_changes = 0;
  logic        oe_prev = 1'b0;

  assign sda_bus = sda_m & ~sda_oe;

  i2c_mem_slave dut (
    .clk     (clk),
    .rst     (rst),
    .scl_i   (scl),
    .sda_i   (sda_bus),
    .sda_oe  (sda_oe),
    .busy    (busy),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus observers: write strobes, any SDA drive or busy, and SDA changes while SCL is high.
  always @(negedge clk) begin
    if (wr_en) act_wr.push_back({wr_addr, wr_data});
    if (sda_oe) any_oe = 1'b1;
    if (busy) any_busy = 1'b1;
    if (!rst && scl && sda_oe !== oe_prev) oe_hi_changes++;
    oe_prev = sda_oe;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: run did not complete, got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic void ref_reset();
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
    ref_ptr = 0;
  endfunction

  function automatic void ref_write(input logic [7:0] p, input byte_q_t d);
    ref_ptr = int'(p) % 16;
    foreach (d[i]) begin
      ref_mem[ref_ptr] = d[i];
      exp_wr.push_back({4'(ref_ptr), d[i]});
      ref_ptr = (ref_ptr + 1) % 16;
    end
  endfunction

  function automatic logic [7:0] ref_read();
    logic [7:0] r;
    r = ref_mem[ref_ptr];
    ref_ptr = (ref_ptr + 1) % 16;
    return r;
  endfunction

  // ---------------- bus master primitives ----------------
  task automatic clk_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_bit(input logic b, output logic sampled);
    clk_wait(2);
    sda_m = b;
    clk_wait(4);
    scl = 1'b1;
    clk_wait(3);
    sampled = sda_bus;
    clk_wait(3);
    scl = 1'b0;
  endtask

  task automatic start_cond();
    sda_m = 1'b1;
    clk_wait(4);
    scl = 1'b1;
    clk_wait(5);
    sda_m = 1'b0;
    clk_wait(5);
    scl = 1'b0;
  endtask

  task automatic stop_cond();
    clk_wait(2);
    sda_m = 1'b0;
    clk_wait(4);
    scl = 1'b1;
    clk_wait(5);
    sda_m = 1'b1;
    clk_wait(5);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(d[i], s);
    bus_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, s);
      d[i] = s;
    end
    bus_bit(mack, s);
  endtask

  task automatic master_write(input byte_q_t bytes, input bit do_stop, output int nacks);
    logic a;
    nacks = 0;
    start_cond();
    foreach (bytes[i]) begin
      write_byte(bytes[i], a);
      if (a) nacks++;
    end
    if (do_stop) stop_cond();
  endtask

  task automatic master_read(input int n, output byte_q_t data, output int nacks);
    logic       a;
    logic [7:0] d;
    data = {};
    start_cond();
    write_byte(8'h3F, a);
    nacks = a ? 1 : 0;
    for (int k = 0; k < n; k++) begin
      read_byte(k == n - 1, d);
      data.push_back(d);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    clk_wait(3);
    tests_run++;
    if (sda_oe !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_sda_oe got %b want 0", sda_oe); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    tests_run++;
    if (wr_en !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_wr_en got %b want 0", wr_en); end
    tests_run++;
    if (wr_addr !== 4'h0) begin tests_failed++; $display("[TB] FAIL reset_wr_addr got %h want 0", wr_addr); end
    tests_run++;
    if (wr_data !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_wr_data got %h want 00", wr_data); end
    rst = 1'b0;
    ref_reset();
    clk_wait(4);
  endtask

  task automatic test_write_basic();
    int n;
    act_wr.delete(); exp_wr.delete();
    master_write('{8'h3E, 8'h05, 8'h0E}, 1'b0, n);
    ref_write(8'h05, '{8'h0E});
    tests_run++;
    if (n !== 0) begin tests_failed++; $display("[TB] FAIL basic_acks got %0d nacks want 0", n); end
    tests_run++;
    if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL basic_busy_mid got %b want 1", busy); end
    stop_cond();
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_busy_stop got %b want 0", busy); end
    tests_run++;
    if (act_wr.size() != 1 || act_wr[0] !== exp_wr[0])
      begin tests_failed++; $display("[TB] FAIL basic_wr got %0d strobes first %h want 1 strobe %h", act_wr.size(), (act_wr.size() > 0) ? act_wr[0] : 12'hxxx, exp_wr[0]); end
  endtask

  task automatic test_repeated_start_read();
    int n, n2;
    byte_q_t d;
    logic [7:0] e;
    master_write('{8'h3E, 8'h05}, 1'b0, n);
    ref_write(8'h05, '{});
    master_read(1, d, n2);
    e = ref_read();
    tests_run++;
    if (n + n2 != 0) begin tests_failed++; $display("[TB] FAIL rs_acks got %0d nacks want 0", n + n2); end
    tests_run++;
    if (d[0] !== e) begin tests_failed++; $display("[TB] FAIL rs_data got %h want %h", d[0], e); end
    tests_run++;
    if (sda_oe !== 1'b0 || busy !== 1'b0)
      begin tests_failed++; $display("[TB] FAIL rs_after_nack got oe=%b busy=%b want 0 0", sda_oe, busy); end
    stop_cond();
  endtask

  task automatic test_wrap();
    int n, n2;
    byte_q_t d;
    logic [7:0] e;
    act_wr.delete(); exp_wr.delete();
    master_write('{8'h3E, 8'h0F, 8'hAA, 8'hBB}, 1'b1, n);
    ref_write(8'h0F, '{8'hAA, 8'hBB});
    tests_run++;
    if (n !== 0) begin tests_failed++; $display("[TB] FAIL wrap_acks got %0d nacks want 0", n); end
    tests_run++;
    if (act_wr.size() != 2) begin tests_failed++; $display("[TB] FAIL wrap_wr_count got %0d want 2", act_wr.size()); end
    else for (int i = 0; i < 2; i++) begin
      tests_run++;
      if (act_wr[i] !== exp_wr[i]) begin tests_failed++; $display("[TB] FAIL wrap_wr%0d got %h want %h", i, act_wr[i], exp_wr[i]); end
    end
    master_write('{8'h3E, 8'h0F}, 1'b0, n);
    ref_write(8'h0F, '{});
    master_read(2, d, n2);
    stop_cond();
    for (int i = 0; i < 2; i++) begin
      e = ref_read();
      tests_run++;
      if (d[i] !== e) begin tests_failed++; $display("[TB] FAIL wrap_rd%0d got %h want %h", i, d[i], e); end
    end
  endtask

  task automatic test_wrong_addr();
    int n;
    act_wr.delete();
    any_oe = 1'b0; any_busy = 1'b0;
    master_write('{8'hC7, 8'($urandom_range(0, 255))}, 1'b1, n);
    tests_run++;
    if (n !== 2) begin tests_failed++; $display("[TB] FAIL wrong_nacks got %0d want 2", n); end
    tests_run++;
    if (any_oe !== 1'b0) begin tests_failed++; $display("[TB] FAIL wrong_sda_oe got driven want never"); end
    tests_run++;
    if (any_busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL wrong_busy got high want low"); end
    tests_run++;
    if (act_wr.size() != 0) begin tests_failed++; $display("[TB] FAIL wrong_wr got %0d strobes want 0", act_wr.size()); end
  endtask

  task automatic test_reset_mid();
    int n, n2;
    logic s;
    byte_q_t d;
    logic [7:0] e;
    master_write('{8'h3E, 8'h09}, 1'b0, n);
    for (int i = 0; i < 4; i++) bus_bit(1'($urandom_range(0, 1)), s);
    tests_run++;
    if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL rstmid_busy_before got %b want 1", busy); end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (sda_oe !== 1'b0 || busy !== 1'b0)
      begin tests_failed++; $display("[TB] FAIL rstmid_async got oe=%b busy=%b want 0 0", sda_oe, busy); end
    clk_wait(3);
    rst = 1'b0;
    sda_m = 1'b1;
    ref_reset();
    clk_wait(2);
    scl = 1'b1;
    clk_wait(6);
    act_wr.delete(); exp_wr.delete();
    master_write('{8'h3E, 8'h02, 8'h55}, 1'b1, n);
    ref_write(8'h02, '{8'h55});
    tests_run++;
    if (n !== 0) begin tests_failed++; $display("[TB] FAIL rstmid_acks got %0d nacks want 0", n); end
    tests_run++;
    if (act_wr.size() != 1 || act_wr[0] !== exp_wr[0])
      begin tests_failed++; $display("[TB] FAIL rstmid_wr got %0d strobes want 1 of %h", act_wr.size(), exp_wr[0]); end
    master_write('{8'h3E, 8'h00}, 1'b0, n);
    ref_write(8'h00, '{});
    master_read(3, d, n2);
    stop_cond();
    for (int i = 0; i < 3; i++) begin
      e = ref_read();
      tests_run++;
      if (d[i] !== e) begin tests_failed++; $display("[TB] FAIL rstmid_rd%0d got %h want %h", i, d[i], e); end
    end
  endtask

  task automatic test_stop_mid();
    int n;
    logic s;
    logic [7:0] v;
    act_wr.delete(); exp_wr.delete();
    master_write('{8'h3E, 8'h03}, 1'b0, n);
    ref_write(8'h03, '{});
    for (int i = 0; i < 4; i++) bus_bit(1'($urandom_range(0, 1)), s);
    stop_cond();
    tests_run++;
    if (act_wr.size() != 0) begin tests_failed++; $display("[TB] FAIL stopmid_wr got %0d strobes want 0", act_wr.size()); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL stopmid_busy got %b want 0", busy); end
    v = 8'($urandom_range(0, 255));
    master_write('{8'h3E, 8'h03, v}, 1'b1, n);
    ref_write(8'h03, '{v});
    tests_run++;
    if (n !== 0) begin tests_failed++; $display("[TB] FAIL stopmid_next_acks got %0d nacks want 0", n); end
    tests_run++;
    if (act_wr.size() != 1 || act_wr[0] !== exp_wr[0])
      begin tests_failed++; $display("[TB] FAIL stopmid_next_wr got %0d strobes want 1 of %h", act_wr.size(), exp_wr[0]); end
  endtask

  task automatic test_random();
    int n, n2, len;
    logic [7:0] p, e;
    byte_q_t data, d, frame;
    for (int it = 0; it < 6; it++) begin
      act_wr.delete(); exp_wr.delete();
      p = 8'($urandom_range(0, 255));
      len = $urandom_range(1, 5);
      data = {};
      for (int k = 0; k < len; k++) data.push_back(8'($urandom_range(0, 255)));
      frame = {8'h3E, p};
      foreach (data[k]) frame.push_back(data[k]);
      master_write(frame, 1'b1, n);
      ref_write(p, data);
      tests_run++;
      if (n !== 0) begin tests_failed++; $display("[TB] FAIL rand%0d_wr_acks got %0d nacks want 0", it, n); end
      tests_run++;
      if (act_wr.size() != exp_wr.size())
        begin tests_failed++; $display("[TB] FAIL rand%0d_wr_count got %0d want %0d", it, act_wr.size(), exp_wr.size()); end
      else foreach (exp_wr[k]) begin
        tests_run++;
        if (act_wr[k] !== exp_wr[k])
          begin tests_failed++; $display("[TB] FAIL rand%0d_wr%0d got %h want %h", it, k, act_wr[k], exp_wr[k]); end
      end
      if ($urandom_range(0, 1) == 1) begin
        p = 8'($urandom_range(0, 255));
        master_write('{8'h3E, p}, 1'b0, n);
        ref_write(p, '{});
      end
      len = $urandom_range(1, 5);
      master_read(len, d, n2);
      stop_cond();
      for (int k = 0; k < len; k++) begin
        e = ref_read();
        tests_run++;
        if (d[k] !== e) begin tests_failed++; $display("[TB] FAIL rand%0d_rd%0d got %h want %h", it, k, d[k], e); end
      end
    end
    tests_run++;
    if (oe_hi_changes != 0)
      begin tests_failed++; $display("[TB] FAIL oe_while_scl_high got %0d changes want 0", oe_hi_changes); end
  endtask

  initial begin
    scl   = 1'b1;
    sda_m = 1'b1;
    rst   = 1'b1;
    test_reset();
    test_write_basic();
    test_repeated_start_read();
    test_wrap();
    test_wrong_addr();
    test_reset_mid();
    test_stop_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/i2c_mem_slave.md
# i2c_mem_slave

Open-drain I2C target with a small register memory, sitting on the bus downstream of the team's I2C master wrapper. It consumes the master's SCL/SDA and ACKs its own 7-bit device address. It accepts a register-pointer byte and then writes or returns memory bytes with pointer auto-increment. It is the memory target that the master's write/read/wrong-address traffic is exercised against.

## Interface
- SLAVE_ADDR, 7'h1F, device address matched against bits [7:1] of the first byte after START
- MEM_DEPTH, 16, number of 8-bit locations; power of two, 2..256
- clk  in  1  system clock; SCL/SDA are sampled in this domain
- rst  in  1  asynchronous, active-high reset
- scl_i  in  1  bus clock from master
- sda_i  in  1  resolved bus data line
- sda_oe  out  1  1 = pull SDA low; 0 = release
- busy  out  1  high from a matching address until STOP, a mismatch, or the end of a read
- wr_en  out  1  one-cycle strobe on each memory write
- wr_addr  out  $clog2(MEM_DEPTH)  location written
- wr_data  out  8  byte written

## Operation
- Bus frontend: 2-flop synchronizers on scl_i/sda_i, plus previous-sample registers.
  - SCL rise and SCL fall detected as events.
  - START = SDA falls while SCL is high. STOP = SDA rises while SCL is high.
- FSM states: IDLE, DEV_ADDR, DEV_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK.
- START from any state, including a repeated start, goes to DEV_ADDR with bit count 0 and sda_oe 0. STOP from any state goes to IDLE.
- Data bits are shifted MSB first on SCL rise. A 3-bit counter tracks position; the 8th rise completes a byte.
- DEV_ADDR complete:
  - If byte[7:1]==SLAVE_ADDR, go to DEV_ACK.
  - Otherwise go to IDLE, ignore the bus until the next START, and never drive SDA.
- ACK slots (DEV_ACK, PTR_ACK, WR_ACK):
  - Assert sda_oe on the SCL fall that ends the 8th bit.
  - Release sda_oe on the next SCL fall.
- After DEV_ACK: go to PTR if R/W=0, or RD_DATA if R/W=1.
- PTR complete: ptr <= byte mod MEM_DEPTH (upper bits ignored). Then PTR_ACK, then WR_DATA.
- WR_DATA complete:
  - mem[ptr] <= byte. Pulse wr_en with wr_addr=ptr and wr_data=byte.
  - ptr increments and wraps from MEM_DEPTH-1 to 0. Then WR_ACK, then WR_DATA again.
- RD_DATA:
  - On entry, load shift register with mem[ptr] and increment ptr (wrapping).
  - Drive sda_oe = ~bit for each bit, updating on SCL fall; the MSB is driven on the fall that ends the ACK slot.
  - After the 8th bit, release SDA and go to RD_ACK.
- RD_ACK: sample SDA on SCL rise.
  - 0 (ACK): go to RD_DATA and load the next byte.
  - 1 (NACK): go to IDLE, keeping SDA released.
- ptr persists across transactions. A read without a preceding pointer write starts at the current ptr.

## Timing
- Reset values:
  - sda_oe=0, busy=0, wr_en=0, wr_addr=0, wr_data=0.
  - ptr=0, all memory locations 0, state IDLE.
  - Reset takes effect immediately (asynchronous), including mid-byte; the bus is released in the same cycle.
- Event latency: 3 clk from a pin change to FSM action (2 synchronizer stages + edge register).
- Bus constraint: SCL high and low phases are each ≥ 4 clk. SDA changes from the master occur ≥ 1 clk after SCL falls.
- sda_oe changes 1 clk after a detected SCL fall event, and never while SCL is high. The only exceptions are reset and START/STOP release.
- wr_en fires 1 clk after the 8th SCL rise of a WR_DATA byte.
- Simultaneous START/STOP and SCL edge in one cycle: START/STOP wins.

## Structure
- Shared package i2c_pkg:
  - state enum i2c_slv_state_t.
  - constants ACK=1'b0, NACK=1'b1, BYTE_BITS=8.
  - a bus_event_t struct with fields scl_rise, scl_fall, start, stop.
- Sub-module i2c_bus_sync: synchronizers, edge registers, and START/STOP detection. It outputs bus_event_t and the synchronized sda.
- Top module: FSM, counter, shift register, ptr, and memory array.

## Test plan
- Write 0x3E, 0x05, 0x0E, then STOP → ACK low in all 3 slots; wr_en pulses once with wr_addr=5 and wr_data=0x0E; busy falls after STOP.
- Write 0x3E, 0x05, then repeated START, 0x3F, master NACK → slave shifts out 0x0E MSB-first; after the NACK sda_oe=0 and state is IDLE.
- Write 0x3E, 0x0F, 0xAA, 0xBB; then read 0x3F from ptr 0x0F with ACK then NACK → mem[15]=0xAA, mem[0]=0xBB (wrap); read returns 0xAA then 0xBB.
- Address byte 0xC7 followed by 8 more clocked bits → sda_oe stays 0 throughout; no wr_en pulse; busy stays 0.
- Reset asserted at bit 4 of a data byte → sda_oe=0 and busy=0 in the same cycle, ptr=0; a following 0x3E/0x02/0x55 write works normally.
- STOP injected mid-byte during WR_DATA → no write occurs; state is IDLE; the next START is accepted.
